// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL / SoC reset sequencer.
// State encoding, default cycle counts and the counter width helper.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_SOFT      = 3'd4
   } state_t;

   localparam int DEF_RESET_CYCLES    = 16;
   localparam int DEF_STABLE_CYCLES   = 1024;
   localparam int DEF_TIMEOUT_CYCLES  = 65536;
   localparam int DEF_SOFT_RST_CYCLES = 8;
   localparam int DEF_RETRY_W         = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold (max_count - 1), never less than one.
   function automatic int cnt_width(input int max_count);
      if (max_count <= 2) return 1;
      return $clog2(max_count);
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// Generic two-flop synchroniser, asynchronously reset to 0.
module sync2 (
   input  logic ck,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// Power-up sequencer for the iCE40 PLL and SoC reset, clocked by the board reference clock.
// Optional WAIT_LOCK timeout/retry is enabled by defining PLL_CTRL_TIMEOUT_EN.
//
// state        | meaning
// PLL_RESET    | PLL held in reset (RESETB low) for RESET_CYCLES
// WAIT_LOCK    | PLL running, waiting for synchronised LOCK
// STABLE       | LOCK must stay high for STABLE_CYCLES
// RUN          | SoC out of reset, ready high
// SOFT         | software-requested timed SoC reset
module pll_reset_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
   parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter int SOFT_RST_CYCLES = DEF_SOFT_RST_CYCLES,
   parameter int RETRY_W         = DEF_RETRY_W
) (
   input  logic               ck,
   input  logic               rst_n,
   input  logic               pll_lock,
   input  logic               soft_req,
   output logic               pll_resetb,
   output logic               sys_rst,
   output logic               ready,
   output logic [RETRY_W-1:0] retries
);

   localparam int MAXC = max2(max2(RESET_CYCLES, STABLE_CYCLES),
                              max2(TIMEOUT_CYCLES, SOFT_RST_CYCLES));
   localparam int CW   = cnt_width(MAXC);

   localparam logic [CW-1:0] LD_RESET  = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] LD_SOFT   = CW'(SOFT_RST_CYCLES - 1);
`ifdef PLL_CTRL_TIMEOUT_EN
   localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [RETRY_W-1:0] r_retries;
   logic               r_soft_q;
   logic               r_pll_resetb;
   logic               r_sys_rst;
   logic               r_ready;
   logic               w_lock_s;
   logic               w_soft_edge;
   logic               w_retry_inc;

   sync2 u_lock_sync (
      .ck    (ck),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (w_lock_s)
   );

   assign w_soft_edge = soft_req & ~r_soft_q;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_inc = 1'b0;
      case (r_state)
         ST_PLL_RESET: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_WAIT_LOCK;
`ifdef PLL_CTRL_TIMEOUT_EN
               w_cnt_nxt   = LD_TIMEOUT;
`endif
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (w_lock_s) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = LD_STABLE;
            end
`ifdef PLL_CTRL_TIMEOUT_EN
            else if (r_cnt == '0) begin
               w_state_nxt = ST_PLL_RESET;
               w_cnt_nxt   = LD_RESET;
               w_retry_inc = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
`endif
         end
         ST_STABLE: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
`ifdef PLL_CTRL_TIMEOUT_EN
               w_cnt_nxt   = LD_TIMEOUT;
`endif
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_RUN: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_PLL_RESET;
               w_cnt_nxt   = LD_RESET;
               w_retry_inc = 1'b1;
            end else if (w_soft_edge) begin
               w_state_nxt = ST_SOFT;
               w_cnt_nxt   = LD_SOFT;
            end
         end
         ST_SOFT: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_PLL_RESET;
               w_cnt_nxt   = LD_RESET;
               w_retry_inc = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_PLL_RESET;
            w_cnt_nxt   = LD_RESET;
         end
      endcase
   end

   // Outputs are registered from the next state so they change with the state register.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_PLL_RESET;
         r_cnt        <= LD_RESET;
         r_retries    <= '0;
         r_soft_q     <= 1'b0;
         r_pll_resetb <= 1'b0;
         r_sys_rst    <= 1'b1;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_soft_q     <= soft_req;
         r_pll_resetb <= (w_state_nxt != ST_PLL_RESET);
         r_sys_rst    <= (w_state_nxt != ST_RUN);
         r_ready      <= (w_state_nxt == ST_RUN);
         if (w_retry_inc && (r_retries != '1))
            r_retries <= r_retries + RETRY_W'(1);
      end
   end

   assign pll_resetb = r_pll_resetb;
   assign sys_rst    = r_sys_rst;
   assign ready      = r_ready;
   assign retries    = r_retries;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: directed scenarios plus randomized lock/soft_req
// traffic, compared every cycle against a phase/elapsed-time model.
module tb_pll_reset_ctrl;

   localparam int RC = 4;
   localparam int SC = 8;
   localparam int TC = 32;
   localparam int FC = 3;
   localparam int RW = 2;
`ifdef PLL_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          ck = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_lock = 1'b0;
   logic          soft_req = 1'b0;
   logic          pll_resetb;
   logic          sys_rst;
   logic          ready;
   logic [RW-1:0] retries;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   pll_reset_ctrl #(
      .RESET_CYCLES    (RC),
      .STABLE_CYCLES   (SC),
      .TIMEOUT_CYCLES  (TC),
      .SOFT_RST_CYCLES (FC),
      .RETRY_W         (RW)
   ) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .pll_lock   (pll_lock),
      .soft_req   (soft_req),
      .pll_resetb (pll_resetb),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .retries    (retries)
   );

   always #5 ck = ~ck;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: phase plus time spent in it; lock seen two edges late.
   localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_SOFT = 4;
   int m_phase, m_t, m_ret;
   bit m_lh1, m_lh2, m_softq;

   function automatic int sat_inc(input int v);
      return (v < (1 << RW) - 1) ? v + 1 : v;
   endfunction

   always @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_RST; m_t = 0; m_ret = 0;
         m_lh1 = 0; m_lh2 = 0; m_softq = 0;
      end else begin
         case (m_phase)
            P_RST:  if (m_t == RC - 1) begin m_phase = P_WAIT; m_t = 0; end else m_t++;
            P_WAIT: if (m_lh2) begin m_phase = P_STAB; m_t = 0; end
                    else if (TO_EN && m_t == TC - 1) begin m_phase = P_RST; m_t = 0; m_ret = sat_inc(m_ret); end
                    else m_t++;
            P_STAB: if (!m_lh2) begin m_phase = P_WAIT; m_t = 0; end
                    else if (m_t == SC - 1) m_phase = P_RUN;
                    else m_t++;
            P_RUN:  if (!m_lh2) begin m_phase = P_RST; m_t = 0; m_ret = sat_inc(m_ret); end
                    else if (soft_req && !m_softq) begin m_phase = P_SOFT; m_t = 0; end
            default: if (!m_lh2) begin m_phase = P_RST; m_t = 0; m_ret = sat_inc(m_ret); end
                    else if (m_t == FC - 1) m_phase = P_RUN;
                    else m_t++;
         endcase
         m_lh2 = m_lh1;
         m_lh1 = pll_lock;
         m_softq = soft_req;
      end
   end

   always @(negedge ck) begin
      if (rst_n && chk_en) begin
         check("model pll_resetb", int'(pll_resetb), int'(m_phase != P_RST));
         check("model sys_rst",    int'(sys_rst),    int'(m_phase != P_RUN));
         check("model ready",      int'(ready),      int'(m_phase == P_RUN));
         check("model retries",    int'(retries),    m_ret);
      end
   end

   task automatic do_reset(input bit lock_val);
      @(negedge ck);
      rst_n = 1'b0; pll_lock = lock_val; soft_req = 1'b0;
      @(negedge ck);
      @(negedge ck);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 300) begin @(posedge ck); #1; n++; end
      if (!ready) check({name, " timeout"}, 0, 1);
   endtask

   initial begin
      int n, rb_n, hi, first_hi, bad_rb;

      // Reset values
      rst_n = 1'b0; pll_lock = 1'b1;
      #13;
      check("rst pll_resetb", int'(pll_resetb), 0);
      check("rst sys_rst", int'(sys_rst), 1);
      check("rst ready", int'(ready), 0);
      check("rst retries", int'(retries), 0);
      chk_en = 1'b1;

      // 1: power-up with lock already high
      do_reset(1'b1);
      n = 0; rb_n = -1;
      while (!ready && n < 200) begin
         @(posedge ck); #1; n++;
         if (pll_resetb && rb_n < 0) rb_n = n;
      end
      check("t1 pll_resetb release edge", rb_n, RC);
      check("t1 ready edge", n, RC + 1 + SC);

      // 2: one-cycle lock glitch in STABLE
      do_reset(1'b1);
      repeat (7) @(negedge ck);
      pll_lock = 1'b0;
      @(negedge ck);
      pll_lock = 1'b1;
      n = 0;
      while (!ready && n < 200) begin @(posedge ck); #1; n++; end
      check("t2 edges lock-recover to ready", n, 2 + 1 + SC);

      // 3: no lock at all
      do_reset(1'b0);
      if (TO_EN) begin
         for (int k = 1; k <= 5; k++) begin
            repeat (RC + TC - 1) @(posedge ck);
            #1 check("t3 retries before timeout", int'(retries), (k - 1 > 3) ? 3 : k - 1);
            @(posedge ck);
            #1 check("t3 retries after timeout", int'(retries), (k > 3) ? 3 : k);
            check("t3 back in PLL reset", int'(pll_resetb), 0);
         end
      end else begin
         repeat (200) @(posedge ck);
         #1 check("t3 no timeout retries", int'(retries), 0);
         check("t3 waiting pll_resetb", int'(pll_resetb), 1);
      end

      // 4: lock loss in RUN
      do_reset(1'b1);
      wait_ready("t4 reach RUN");
      @(negedge ck);
      pll_lock = 1'b0;
      repeat (2) @(posedge ck);
      #1 check("t4 ready after 2", int'(ready), 1);
      @(posedge ck);
      #1 check("t4 ready after 3", int'(ready), 0);
      check("t4 sys_rst after 3", int'(sys_rst), 1);
      check("t4 pll_resetb after 3", int'(pll_resetb), 0);
      check("t4 retries after 3", int'(retries), 1);
      @(negedge ck);
      pll_lock = 1'b1;
      wait_ready("t4 recover");

      // 5: soft_req held for 10 cycles
      @(negedge ck);
      soft_req = 1'b1;
      hi = 0; first_hi = -1; bad_rb = 0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge ck); #1;
         if (sys_rst) begin hi++; if (first_hi < 0) first_hi = i; end
         if (!pll_resetb) bad_rb++;
         if (i == 10) soft_req = 1'b0;
      end
      check("t5 sys_rst pulse length", hi, FC);
      check("t5 sys_rst rise edge", first_hi, 1);
      check("t5 pll_resetb low cycles", bad_rb, 0);
      check("t5 ready restored", int'(ready), 1);

      // 6: rst_n during SOFT
      @(negedge ck);
      soft_req = 1'b1;
      @(posedge ck);
      #1 check("t6 in SOFT", int'(sys_rst), 1);
      check("t6 retries before", int'(retries), 1);
      #2 rst_n = 1'b0;
      #1 check("t6 pll_resetb", int'(pll_resetb), 0);
      check("t6 sys_rst", int'(sys_rst), 1);
      check("t6 ready", int'(ready), 0);
      check("t6 retries", int'(retries), 0);
      soft_req = 1'b0;

      // Random lock / soft_req traffic against the model
      do_reset(1'b1);
      for (int c = 0; c < 4000; c++) begin
         @(negedge ck);
         if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
         if ($urandom_range(0, 5) == 0) soft_req = ~soft_req;
      end
      @(negedge ck);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
